// File: rtl/ps2_paddle_ctrl.sv
// ps2_paddle_ctrl: decodes PS/2 make/break/extended scan codes into held-key
// state for two players and moves both paddles on a fixed-rate tick.
// Player A: W (1D) up, S (1B) down. Player B: E0 75 up, E0 72 down.
// Optional: define PADDLE_ACCEL_EN to double the step after 8 consecutive
// same-direction movement ticks.
module ps2_paddle_ctrl #(
    parameter int TICK_DIV = 833333,
    parameter int STEP     = 4,
    parameter int Y_MAX    = 440,
    parameter int INIT_Y   = 200,
    parameter int TIMEOUT  = 5000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] code_in,
    input  logic       code_valid,
    output logic [9:0] pos_a,
    output logic [9:0] pos_b,
    output logic [3:0] held,
    output logic       tick,
    output logic       busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] EXT     = 2'd1;
    localparam logic [1:0] BRK     = 2'd2;
    localparam logic [1:0] EXT_BRK = 2'd3;

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [10:0]   STEP_W   = 11'(STEP);
    localparam logic [10:0]   YMAX_W   = 11'(Y_MAX);

    logic [1:0]      state;
    logic [TW-1:0]   to_cnt;
    logic [DW-1:0]   div_cnt;
    logic [1:0][9:0] pos;
    logic [1:0][10:0] step;

    assign pos_a = pos[0];
    assign pos_b = pos[1];
    assign busy  = (state != IDLE);

    // One movement with clamping; 11-bit intermediates keep the sum from wrapping.
    function automatic logic [9:0] move(input logic [9:0] p, input logic up,
                                        input logic dn, input logic [10:0] st);
        logic [10:0] w;
        w = {1'b0, p};
        if (up && !dn)
            move = (w >= st) ? 10'(w - st) : 10'd0;
        else if (dn && !up)
            move = (w + st <= YMAX_W) ? 10'(w + st) : 10'(YMAX_W);
        else
            move = p;
    endfunction

    // Scan-code decoder with prefix timeout; AA (self-test) wipes all keys.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            held   <= 4'b0;
            to_cnt <= '0;
        end else if (code_valid) begin
            to_cnt <= '0;
            if (code_in == 8'hAA) begin
                held  <= 4'b0;
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (code_in == 8'hE0)      state <= EXT;
                        else if (code_in == 8'hF0) state <= BRK;
                        else if (code_in == 8'h1D) held[0] <= 1'b1;
                        else if (code_in == 8'h1B) held[1] <= 1'b1;
                    end
                    EXT: begin
                        if (code_in == 8'hF0)      state <= EXT_BRK;
                        else if (code_in == 8'hE0) state <= EXT;
                        else begin
                            state <= IDLE;
                            if (code_in == 8'h75) held[2] <= 1'b1;
                            if (code_in == 8'h72) held[3] <= 1'b1;
                        end
                    end
                    BRK: begin
                        state <= IDLE;
                        if (code_in == 8'h1D) held[0] <= 1'b0;
                        if (code_in == 8'h1B) held[1] <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        if (code_in == 8'h75) held[2] <= 1'b0;
                        if (code_in == 8'h72) held[3] <= 1'b0;
                    end
                endcase
            end
        end else if (state == IDLE) begin
            to_cnt <= '0;
        end else if (to_cnt == TO_LAST) begin
            state  <= IDLE;
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Frame divider; tick is registered so it lands the cycle after the wrap value.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

`ifdef PADDLE_ACCEL_EN
    logic [1:0][3:0] run;
    logic [1:0]      dir;   // last moving direction, 1 = down

    // Per-player step doubles once the run counter has saturated.
    always_comb begin
        for (int p = 0; p < 2; p++)
            step[p] = (run[p] == 4'd8) ? 11'(STEP_W << 1) : STEP_W;
    end

    // Run counters: count consecutive same-direction moving ticks, saturate at 8.
    always_ff @(posedge clock) begin
        if (reset) begin
            run <= '0;
            dir <= '0;
        end else if (tick) begin
            for (int p = 0; p < 2; p++) begin
                if ((held[2*p] ^ held[2*p+1]) && (run[p] == 4'd0 || dir[p] == held[2*p+1])) begin
                    run[p] <= (run[p] == 4'd8) ? 4'd8 : run[p] + 4'd1;
                    dir[p] <= held[2*p+1];
                end else begin
                    run[p] <= 4'd0;
                end
            end
        end
    end
`else
    assign step = {2{STEP_W}};
`endif

    // Paddle positions move on tick using the held state from before this edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            pos <= {2{10'(INIT_Y)}};
        end else if (tick) begin
            for (int p = 0; p < 2; p++)
                pos[p] <= move(pos[p], held[2*p], held[2*p+1], step[p]);
        end
    end

endmodule

// File: tb/tb_ps2_paddle_ctrl.sv
// Testbench for ps2_paddle_ctrl: table-driven decoder vectors, hand-written
// multi-cycle sequences and random byte traffic, all compared every cycle
// against a behavioural model of the key/paddle rules.
module tb_ps2_paddle_ctrl;

    localparam int TICK_DIV = 10;
    localparam int STEP     = 4;
    localparam int Y_MAX    = 440;
    localparam int INIT_Y   = 200;
    localparam int TIMEOUT  = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] code_in = 8'h00;
    logic       code_valid = 1'b0;
    logic [9:0] pos_a, pos_b;
    logic [3:0] held;
    logic       tick, busy;

    int errors = 0;
    int checks = 0;

    ps2_paddle_ctrl #(
        .TICK_DIV(TICK_DIV), .STEP(STEP), .Y_MAX(Y_MAX),
        .INIT_Y(INIT_Y), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
        .pos_a(pos_a), .pos_b(pos_b), .held(held), .tick(tick), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: keys as booleans, prefix as two flags, tick from edge count.
    int m_pos[2];
    bit m_key[4];      // a_up, a_dn, b_up, b_dn
    bit m_ext, m_brk;
    int m_quiet;
    int m_edges;

    function automatic int mheld();
        return {m_key[3], m_key[2], m_key[1], m_key[0]};
    endfunction

    task automatic model_edge(input bit rst, input bit v, input logic [7:0] c);
        if (rst) begin
            m_pos[0] = INIT_Y; m_pos[1] = INIT_Y;
            for (int k = 0; k < 4; k++) m_key[k] = 0;
            m_ext = 0; m_brk = 0; m_quiet = 0; m_edges = 0;
            return;
        end
        if (m_edges > 0 && m_edges % TICK_DIV == 0) begin
            for (int p = 0; p < 2; p++) begin
                if (m_key[2*p] && !m_key[2*p+1])
                    m_pos[p] = (m_pos[p] - STEP < 0) ? 0 : m_pos[p] - STEP;
                else if (m_key[2*p+1] && !m_key[2*p])
                    m_pos[p] = (m_pos[p] + STEP > Y_MAX) ? Y_MAX : m_pos[p] + STEP;
            end
        end
        if (v) begin
            m_quiet = 0;
            if (c == 8'hAA) begin
                for (int k = 0; k < 4; k++) m_key[k] = 0;
                m_ext = 0; m_brk = 0;
            end else if (!m_ext && !m_brk) begin
                if (c == 8'hE0) m_ext = 1;
                else if (c == 8'hF0) m_brk = 1;
                else if (c == 8'h1D) m_key[0] = 1;
                else if (c == 8'h1B) m_key[1] = 1;
            end else if (m_ext && !m_brk) begin
                if (c == 8'hF0) m_brk = 1;
                else if (c != 8'hE0) begin
                    if (c == 8'h75) m_key[2] = 1;
                    if (c == 8'h72) m_key[3] = 1;
                    m_ext = 0;
                end
            end else begin
                if (!m_ext) begin
                    if (c == 8'h1D) m_key[0] = 0;
                    if (c == 8'h1B) m_key[1] = 0;
                end else begin
                    if (c == 8'h75) m_key[2] = 0;
                    if (c == 8'h72) m_key[3] = 0;
                end
                m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            m_quiet++;
            if (m_quiet == TIMEOUT) begin
                m_ext = 0; m_brk = 0; m_quiet = 0;
            end
        end
        m_edges++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, model on posedge, compare at next negedge.
    task automatic step(input bit v, input logic [7:0] c);
        code_valid = v;
        code_in = c;
        @(posedge clk);
        model_edge(reset, v, c);
        @(negedge clk);
        code_valid = 1'b0;
        chk("pos_a", int'(pos_a), m_pos[0]);
        chk("pos_b", int'(pos_b), m_pos[1]);
        chk("held", int'(held), mheld());
        chk("tick", int'(tick), int'(m_edges > 0 && m_edges % TICK_DIV == 0));
        chk("busy", int'(busy), int'(m_ext || m_brk));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 8'h00);
        reset = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < n * TICK_DIV + 2 * TICK_DIV) begin
            step(0, 8'h00);
            if (tick) seen++;
            cyc++;
        end
        chk("tick_budget", seen, n);
    endtask

    typedef struct {
        logic [7:0] code;
        logic [3:0] exp_held;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{8'h1D, 4'b0001, 1'b0}, '{8'hE0, 4'b0001, 1'b1}, '{8'h75, 4'b0101, 1'b0},
            '{8'hF0, 4'b0101, 1'b1}, '{8'h1D, 4'b0100, 1'b0}, '{8'h75, 4'b0100, 1'b0},
            '{8'hE0, 4'b0100, 1'b1}, '{8'hF0, 4'b0100, 1'b1}, '{8'h75, 4'b0000, 1'b0},
            '{8'hE0, 4'b0000, 1'b1}, '{8'hE0, 4'b0000, 1'b1}, '{8'h72, 4'b1000, 1'b0},
            '{8'hF0, 4'b1000, 1'b1}, '{8'hE0, 4'b1000, 1'b0}, '{8'h72, 4'b1000, 1'b0},
            '{8'h1B, 4'b1010, 1'b0}, '{8'hE0, 4'b1010, 1'b1}, '{8'h33, 4'b1010, 1'b0},
            '{8'hAA, 4'b0000, 1'b0}, '{8'hE0, 4'b0000, 1'b1}, '{8'hAA, 4'b0000, 1'b0}
        };

        @(negedge clk);
        do_reset();
        chk("rst_pos_a", int'(pos_a), INIT_Y);
        chk("rst_pos_b", int'(pos_b), INIT_Y);
        chk("rst_held", int'(held), 0);
        chk("rst_busy", int'(busy), 0);
        wait_ticks(3);
        chk("idle_pos_a", int'(pos_a), 200);
        chk("idle_pos_b", int'(pos_b), 200);

        // Decoder vector table
        do_reset();
        foreach (vecs[i]) begin
            step(1, vecs[i].code);
            chk("vec_held", int'(held), int'(vecs[i].exp_held));
            chk("vec_busy", int'(busy), int'(vecs[i].exp_busy));
        end

        // Hold W for 5 ticks then release
        do_reset();
        step(1, 8'h1D);
        chk("w_held", int'(held), 1);
        wait_ticks(5);
        step(1, 8'hF0);
        step(1, 8'h1D);
        chk("w_rel_held", int'(held), 0);
        wait_ticks(2);
        chk("w_pos_a", int'(pos_a), 180);
        chk("w_pos_b", int'(pos_b), 200);

        // B down clamps at Y_MAX
        do_reset();
        step(1, 8'hE0);
        chk("ext_busy", int'(busy), 1);
        step(1, 8'h72);
        chk("ext_done_busy", int'(busy), 0);
        wait_ticks(200);
        chk("clamp_b", int'(pos_b), 440);
        wait_ticks(3);
        chk("clamp_b_hold", int'(pos_b), 440);

        // Both keys cancel, then up-only drives pos_a to 0 without wrapping
        do_reset();
        step(1, 8'h1D);
        step(1, 8'h1B);
        wait_ticks(4);
        chk("both_pos_a", int'(pos_a), 200);
        step(1, 8'hF0);
        step(1, 8'h1B);
        wait_ticks(1);
        step(0, 8'h00);
        chk("up_one", int'(pos_a), 196);
        wait_ticks(60);
        chk("floor_a", int'(pos_a), 0);

        // Prefix timeout: a late 72 lands in IDLE and is ignored
        do_reset();
        step(1, 8'hE0);
        repeat (50) step(0, 8'h00);
        chk("to_busy_mid", int'(busy), 1);
        repeat (60) step(0, 8'h00);
        chk("to_busy_after", int'(busy), 0);
        step(1, 8'h72);
        chk("to_held", int'(held), 0);

        // Reset in the middle of a hold
        do_reset();
        step(1, 8'h1D);
        wait_ticks(3);
        do_reset();
        chk("mid_rst_pos_a", int'(pos_a), 200);
        chk("mid_rst_held", int'(held), 0);
        chk("mid_rst_busy", int'(busy), 0);

        // Random byte traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] c;
            int r;
            r = int'($urandom_range(0, 15));
            case (r)
                0, 1:   c = 8'hE0;
                2, 3:   c = 8'hF0;
                4, 5:   c = 8'h1D;
                6, 7:   c = 8'h1B;
                8, 9:   c = 8'h75;
                10, 11: c = 8'h72;
                12:     c = ($urandom_range(0, 7) == 0) ? 8'hAA : 8'h00;
                default: c = 8'($urandom);
            endcase
            step($urandom_range(0, 3) == 0, c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
